misc_alu_pipe: RTL

//  Parametrised successor to the two-stage misc branch: executes the non-MAC block

---
 rtl/misc_alu_pipe.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/misc_alu_pipe.sv
// rtl/misc_alu_pipe.sv - elastic misc-ALU pipeline: acc moves, abs/min/max/clamp, shifts, saturation
// Stage 0 registers operands, stage 1 holds the raw result, the last stage saturates.
module misc_alu_pipe #(
  parameter int data_width = 16,
  parameter int acc_width  = 2 * data_width,
  parameter int n_blocks   = 256,
  parameter int n_stages   = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  input  logic [$clog2(n_blocks)-1:0]   block_in,
  output logic [$clog2(n_blocks)-1:0]   block_out,
  input  logic signed [data_width-1:0]  arg_a_in,
  input  logic signed [data_width-1:0]  arg_b_in,
  input  logic signed [data_width-1:0]  arg_c_in,
  input  logic signed [acc_width-1:0]   accumulator_in,
  input  logic [4:0]                    operation_in,
  input  logic                          saturate_disable_in,
  input  logic [4:0]                    shift_in,
  input  logic [3:0]                    dest_in,
  output logic [3:0]                    dest_out,
  output logic signed [acc_width-1:0]   result_out,
  output logic                          sat_flag_out,
  input  logic [8:0]                    commit_id_in,
  output logic [8:0]                    commit_id_out,
  input  logic                          commit_flag_in,
  output logic                          commit_flag_out
);

  localparam int bw   = $clog2(n_blocks);
  localparam int last = n_stages - 1;
  localparam int mw   = bw + 4 + 9 + 1;
  localparam int half = acc_width / 2;

  localparam logic [4:0] op_mov_acc  = 5'h01;
  localparam logic [4:0] op_mov_uacc = 5'h02;
  localparam logic [4:0] op_mov_lacc = 5'h03;
  localparam logic [4:0] op_abs      = 5'h04;
  localparam logic [4:0] op_min      = 5'h05;
  localparam logic [4:0] op_max      = 5'h06;
  localparam logic [4:0] op_lsh      = 5'h07;
  localparam logic [4:0] op_rsh      = 5'h08;
  localparam logic [4:0] op_arsh     = 5'h09;
  localparam logic [4:0] op_clamp    = 5'h0a;

  localparam logic signed [acc_width-1:0] sat_hi =
    {{(acc_width-data_width+1){1'b0}}, {(data_width-1){1'b1}}};
  localparam logic signed [acc_width-1:0] sat_lo =
    {{(acc_width-data_width+1){1'b1}}, {(data_width-1){1'b0}}};

  logic [n_stages-1:0]            valid_q, valid_d;
  logic [n_stages-1:0][mw-1:0]    meta_q, meta_d;
  logic signed [data_width-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;
  logic signed [acc_width-1:0]    acc_q, acc_d;
  logic [4:0]                     op_q, op_d, sh_q, sh_d;
  logic                           sd0_q, sd0_d;
  logic [last:1][acc_width-1:0]   val_q, val_d;
  logic [last:1]                  sd_q, sd_d;
  logic                           sat_q, sat_d;

  logic [n_stages-1:0]            rdy, take, drained;
  logic                           take_out;
  logic signed [acc_width-1:0]    ax, bx, cx, mx, raw;
  logic [last:1][acc_width-1:0]   val_in;
  logic [last:1]                  sd_in;
  logic [acc_width:0]             sat_res;

  function automatic logic [acc_width:0] saturate(input logic signed [acc_width-1:0] v,
                                                   input logic bypass);
    if (bypass)      return {1'b0, v};
    if (v > sat_hi)  return {1'b1, sat_hi};
    if (v < sat_lo)  return {1'b1, sat_lo};
    return {1'b0, v};
  endfunction

  // A stage can accept when any stage from it to the output has a hole, or the sink drains.
  always_comb begin
    rdy = '0;
    for (int k = 0; k < n_stages; k++) begin
      rdy[k] = out_ready;
      for (int j = k; j < n_stages; j++) begin
        if (!valid_q[j]) rdy[k] = 1'b1;
      end
    end
  end

  always_comb begin
    take    = '0;
    drained = '0;
    take[0] = enable & in_valid & rdy[0];
    for (int k = 1; k < n_stages; k++) take[k] = enable & valid_q[k-1] & rdy[k];
    take_out = enable & valid_q[last] & out_ready;
    for (int k = 0; k < last; k++) drained[k] = take[k+1];
    drained[last] = take_out;
  end

  always_comb begin
    ax  = {{(acc_width-data_width){a_q[data_width-1]}}, a_q};
    bx  = {{(acc_width-data_width){b_q[data_width-1]}}, b_q};
    cx  = {{(acc_width-data_width){c_q[data_width-1]}}, c_q};
    mx  = (ax > bx) ? ax : bx;
    raw = '0;
    case (op_q)
      op_mov_acc:  raw = acc_q >>> sh_q;
      op_mov_uacc: raw = {{(acc_width-half){1'b0}}, acc_q[acc_width-1:half]};
      op_mov_lacc: raw = {{(acc_width-half){1'b0}}, acc_q[half-1:0]};
      op_abs:      raw = ax[acc_width-1] ? -ax : ax;
      op_min:      raw = (ax < bx) ? ax : bx;
      op_max:      raw = mx;
      op_clamp:    raw = (mx < cx) ? mx : cx;
      op_lsh:      raw = ax << sh_q;
      op_rsh:      raw = {{(acc_width-data_width){1'b0}}, a_q} >> sh_q;
      op_arsh:     raw = ax >>> sh_q;
      default:     raw = '0;
    endcase
  end

  always_comb begin
    val_in    = '0;
    sd_in     = '0;
    val_in[1] = raw;
    sd_in[1]  = sd0_q;
    for (int k = 2; k <= last; k++) begin
      val_in[k] = val_q[k-1];
      sd_in[k]  = sd_q[k-1];
    end
  end

  assign sat_res = saturate($signed(val_in[last]), sd_in[last]);

  always_comb begin
    valid_d = valid_q;
    meta_d  = meta_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    acc_d   = acc_q;
    op_d    = op_q;
    sh_d    = sh_q;
    sd0_d   = sd0_q;
    val_d   = val_q;
    sd_d    = sd_q;
    sat_d   = sat_q;
    if (take[0]) begin
      meta_d[0] = {block_in, dest_in, commit_id_in, commit_flag_in};
      a_d       = arg_a_in;
      b_d       = arg_b_in;
      c_d       = arg_c_in;
      acc_d     = accumulator_in;
      op_d      = operation_in;
      sh_d      = shift_in;
      sd0_d     = saturate_disable_in;
    end
    for (int k = 1; k <= last; k++) begin
      if (take[k]) begin
        meta_d[k] = meta_q[k-1];
        val_d[k]  = val_in[k];
        sd_d[k]   = sd_in[k];
      end
    end
    if (take[last]) begin
      val_d[last] = sat_res[acc_width-1:0];
      sat_d       = sat_res[acc_width];
    end
    // A simultaneous load and drain keeps the stage occupied with the new item.
    for (int k = 0; k < n_stages; k++) valid_d[k] = take[k] | (valid_q[k] & ~drained[k]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      meta_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      acc_q   <= '0;
      op_q    <= '0;
      sh_q    <= '0;
      sd0_q   <= 1'b0;
      val_q   <= '0;
      sd_q    <= '0;
      sat_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      meta_q  <= meta_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      sh_q    <= sh_d;
      sd0_q   <= sd0_d;
      val_q   <= val_d;
      sd_q    <= sd_d;
      sat_q   <= sat_d;
    end
  end

  assign in_ready     = enable & rdy[0];
  assign out_valid    = valid_q[last];
  assign result_out   = $signed(val_q[last]);
  assign sat_flag_out = sat_q;
  assign {block_out, dest_out, commit_id_out, commit_flag_out} = meta_q[last];

endmodule
